stg1if: RTL and testbench

Instruction-fetch stage: owns the fetch PC, issues in-order word requests to instruction memory, buffers returned words in a small prefetch FIFO, and presents one instruction per cycle to the decode stage (`stg2id`). Decode latches its inputs on every clock edge. This block therefore holds its outputs on a stall and inserts all-zero bubbles when no instruction is available. It also discards in-flight fetches after a branch redirect from a later stage.

---
 rtl/stg1if.sv | 232 +++++++++++++++++++++++
 tb/tb_stg1if.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stg1if.sv
// stg1if: instruction-fetch stage.
// Issues in-order word fetches from the fetch PC, buffers returned words in a
// small prefetch FIFO and hands one instruction per cycle to decode. Decode
// latches every cycle, so the output register is held on a stall and loaded
// with an all-zero bubble whenever no instruction is available. Responses that
// belong to fetches issued before a redirect are counted and discarded.
module stg1if #(
  parameter int                    SIZE_ADDR = 16,
  parameter int                    SIZE_DATA = 32,
  parameter int                    DEPTH     = 2,
  parameter logic [SIZE_ADDR-1:0]  RESET_PC  = '0
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  output logic                  ow_imem_req,
  output logic [SIZE_ADDR-1:0]  ow_imem_addr,
  input  logic                  iw_imem_rdy,
  input  logic                  iw_imem_rvalid,
  input  logic [SIZE_DATA-1:0]  iw_imem_rdata,
  input  logic                  iw_stall,
  input  logic                  iw_redirect,
  input  logic [SIZE_ADDR-1:0]  iw_redirect_pc,
  output logic [SIZE_ADDR-1:0]  ow_pc,
  output logic [SIZE_DATA-1:0]  ow_instr,
  output logic                  ow_valid
);

  // FIFO pointer width and counter width (counters must hold 2*DEPTH).
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(2 * DEPTH) + 1;

  localparam logic [CW-1:0]        ZERO_C  = '0;
  localparam logic [CW-1:0]        ONE_C   = CW'(1);
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]        CRED_C  = CW'(2 * DEPTH);
  localparam logic [PW-1:0]        PONE_C  = PW'(1);
  localparam logic [SIZE_ADDR-1:0] AONE_C  = SIZE_ADDR'(1);

  // Architectural state.
  logic                  r_run;
  logic [SIZE_ADDR-1:0]  r_fpc;
  logic [SIZE_ADDR-1:0]  r_rpc;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_live;
  logic [CW-1:0]         r_drop;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [SIZE_ADDR-1:0]  r_fifo_pc    [DEPTH];
  logic [SIZE_DATA-1:0]  r_fifo_instr [DEPTH];
  logic [SIZE_ADDR-1:0]  r_out_pc;
  logic [SIZE_DATA-1:0]  r_out_instr;
  logic                  r_out_valid;

  // Combinational control.
  logic                  w_req;
  logic                  w_fire;
  logic                  w_rsp_live;
  logic                  w_rsp_drop;
  logic                  w_adv;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push;
  logic [CW-1:0]         w_live_nxt;
  logic [CW-1:0]         w_drop_nxt;

  // Issue credit, response classification and FIFO/output handshakes.
  always_comb begin
    w_req      = 1'b0;
    w_fire     = 1'b0;
    w_rsp_live = 1'b0;
    w_rsp_drop = 1'b0;
    w_adv      = 1'b0;
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    w_push     = 1'b0;
    // A request needs room in the FIFO for everything live and a bounded
    // number of outstanding (live plus to-be-dropped) responses.
    if (r_run && !iw_redirect &&
        ((r_cnt + r_live) < DEPTH_C) &&
        ((r_live + r_drop) < CRED_C)) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
    w_fire = w_req && iw_imem_rdy;
    if (iw_imem_rvalid && !iw_redirect) begin
      w_rsp_live = (r_drop == ZERO_C);
      w_rsp_drop = (r_drop != ZERO_C);
    end else begin
      w_rsp_live = 1'b0;
      w_rsp_drop = 1'b0;
    end
    w_adv    = !iw_redirect && !iw_stall;
    w_pop    = w_adv && (r_cnt != ZERO_C);
    // Empty FIFO: a live word goes straight to decode without buffering.
    w_bypass = w_adv && (r_cnt == ZERO_C) && w_rsp_live;
    w_push   = w_rsp_live && !w_bypass;
  end

  // Next values of the live-outstanding and drop counters.
  always_comb begin
    w_live_nxt = r_live;
    w_drop_nxt = r_drop;
    if (iw_redirect) begin
      // Everything still live becomes stale; a response arriving right now
      // retires one of those stale fetches immediately.
      w_live_nxt = ZERO_C;
      w_drop_nxt = r_drop + r_live - (iw_imem_rvalid ? ONE_C : ZERO_C);
    end else begin
      w_live_nxt = r_live + (w_fire ? ONE_C : ZERO_C)
                          - (w_rsp_live ? ONE_C : ZERO_C);
      w_drop_nxt = r_drop - (w_rsp_drop ? ONE_C : ZERO_C);
    end
  end

  assign ow_imem_req  = w_req;
  assign ow_imem_addr = r_fpc;
  assign ow_pc        = r_out_pc;
  assign ow_instr     = r_out_instr;
  assign ow_valid     = r_out_valid;

  // Run flag: fetching starts on the first edge after reset release.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Fetch PC and outstanding-response bookkeeping.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_fpc  <= RESET_PC;
      r_live <= ZERO_C;
      r_drop <= ZERO_C;
    end else begin
      r_live <= w_live_nxt;
      r_drop <= w_drop_nxt;
      if (iw_redirect) begin
        r_fpc <= iw_redirect_pc;
      end else if (w_fire) begin
        r_fpc <= r_fpc + AONE_C;
      end else begin
        r_fpc <= r_fpc;
      end
    end
  end

  // Response PC: address of the next live word to come back.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_rpc <= RESET_PC;
    end else if (iw_redirect) begin
      r_rpc <= iw_redirect_pc;
    end else if (w_rsp_live) begin
      r_rpc <= r_rpc + AONE_C;
    end else begin
      r_rpc <= r_rpc;
    end
  end

  // Prefetch FIFO pointers and occupancy; a redirect empties it.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= ZERO_C;
    end else if (iw_redirect) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= ZERO_C;
    end else begin
      r_wptr <= w_push ? (r_wptr + PONE_C) : r_wptr;
      r_rptr <= w_pop  ? (r_rptr + PONE_C) : r_rptr;
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + ONE_C;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - ONE_C;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Prefetch FIFO storage of {pc, instr}.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wptr]    <= r_rpc;
      r_fifo_instr[r_wptr] <= iw_imem_rdata;
    end else begin
      r_fifo_pc[r_wptr]    <= r_fifo_pc[r_wptr];
      r_fifo_instr[r_wptr] <= r_fifo_instr[r_wptr];
    end
  end

  // Output register toward decode: redirect bubble, stall hold, FIFO head,
  // bypassed response, or bubble, in that priority.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end else if (iw_redirect) begin
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end else if (iw_stall) begin
      r_out_pc    <= r_out_pc;
      r_out_instr <= r_out_instr;
      r_out_valid <= r_out_valid;
    end else if (w_pop) begin
      r_out_pc    <= r_fifo_pc[r_rptr];
      r_out_instr <= r_fifo_instr[r_rptr];
      r_out_valid <= 1'b1;
    end else if (w_bypass) begin
      r_out_pc    <= r_rpc;
      r_out_instr <= iw_imem_rdata;
      r_out_valid <= 1'b1;
    end else begin
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stg1if.sv
// tb_stg1if: directed bench for stg1if with an in-order memory model whose
// response data is the request address plus 0x100.
module tb_stg1if;

  localparam int SA    = 16;
  localparam int SD    = 32;
  localparam int DEPTH = 2;

  logic           clk;
  logic           rst_n;
  logic           imem_req;
  logic [SA-1:0]  imem_addr;
  logic           imem_rdy;
  logic           imem_rvalid;
  logic [SD-1:0]  imem_rdata;
  logic           stall;
  logic           redirect;
  logic [SA-1:0]  redirect_pc;
  logic [SA-1:0]  out_pc;
  logic [SD-1:0]  out_instr;
  logic           out_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int lat      = 1;
  bit seen_addr0 = 1'b0;

  logic [SA-1:0] q_addr [$];
  int            q_due  [$];

  stg1if #(
    .SIZE_ADDR (SA),
    .SIZE_DATA (SD),
    .DEPTH     (DEPTH),
    .RESET_PC  (16'h0010)
  ) dut (
    .iw_clk         (clk),
    .iw_rst_n       (rst_n),
    .ow_imem_req    (imem_req),
    .ow_imem_addr   (imem_addr),
    .iw_imem_rdy    (imem_rdy),
    .iw_imem_rvalid (imem_rvalid),
    .iw_imem_rdata  (imem_rdata),
    .iw_stall       (stall),
    .iw_redirect    (redirect),
    .iw_redirect_pc (redirect_pc),
    .ow_pc          (out_pc),
    .ow_instr       (out_instr),
    .ow_valid       (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [SA-1:0] pc,
                           input logic [SD-1:0] instr, input logic valid);
    check_val({tag, "_pc"}, 32'(out_pc), 32'(pc));
    check_val({tag, "_instr"}, out_instr, instr);
    check_val({tag, "_valid"}, 32'(out_valid), 32'(valid));
  endtask

  function automatic logic [SD-1:0] word_of(input logic [SA-1:0] a);
    return {16'h0000, a} + 32'h0000_0100;
  endfunction

  // One clock: memory bookkeeping, edge, present next response, back to negedge.
  task automatic tick();
    logic [SA-1:0] d_a;
    int            d_d;
    #1;
    if (imem_rvalid) begin
      d_a = q_addr.pop_front();
      d_d = q_due.pop_front();
    end
    if (imem_req && imem_rdy) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
      if (imem_addr == 16'h0000) seen_addr0 = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(q_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
    end
    @(negedge clk);
  endtask

  // Advance until the next valid instruction (bounded) and check it.
  task automatic expect_next(input string tag, input logic [SA-1:0] pc);
    int n;
    n = 0;
    tick();
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check_out(tag, pc, word_of(pc), 1'b1);
  endtask

  // Structural invariants: no push into a full FIFO, no unexpected response.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (dut.w_push) check_val("push_not_full", 32'(dut.r_cnt == DEPTH), 32'd0);
      if (imem_rvalid) check_val("rsp_expected", 32'((dut.r_live + dut.r_drop) == 0), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    imem_rdy    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_out("reset", 16'h0, 32'h0, 1'b0);
    check_val("reset_req", 32'(imem_req), 32'd0);
    check_val("reset_addr", 32'(imem_addr), 32'h10);
    rst_n = 1'b1;

    // Startup and streaming with 1-cycle memory.
    tick();
    check_val("start_req", 32'(imem_req), 32'd1);
    check_val("start_addr", 32'(imem_addr), 32'h10);
    check_val("start_valid", 32'(out_valid), 32'd0);
    tick();
    check_val("start_bubble", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stream", 16'h10 + 16'(i), 32'h110 + 32'(i), 1'b1);
    end

    // Memory not ready for 5 cycles.
    imem_rdy = 1'b0;
    tick();
    check_out("rdy_last", 16'h14, 32'h114, 1'b1);
    check_val("rdy_req_addr", 32'(imem_addr), 32'h15);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("rdy_bubble", 16'h0, 32'h0, 1'b0);
    end
    imem_rdy = 1'b1;
    tick();
    check_out("rdy_bubble2", 16'h0, 32'h0, 1'b0);
    tick();
    check_out("rdy_resume0", 16'h15, 32'h115, 1'b1);
    tick();
    check_out("rdy_resume1", 16'h16, 32'h116, 1'b1);

    // Stall for 4 cycles.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stall_hold", 16'h16, 32'h116, 1'b1);
      if (i != 0) check_val("stall_noreq", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check_out("unstall0", 16'h17, 32'h117, 1'b1);
    tick();
    check_out("unstall1", 16'h18, 32'h118, 1'b1);
    tick();
    check_out("unstall2", 16'h19, 32'h119, 1'b1);

    // Redirect to 0x40 with two live 3-cycle fetches.
    lat = 3;
    tick();
    check_out("pre_redir", 16'h1A, 32'h11A, 1'b1);
    tick();
    check_val("pre_redir_live", 32'(dut.r_live), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    check_val("redir_noreq", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    check_out("redir_bubble", 16'h0, 32'h0, 1'b0);
    check_val("redir_drop", 32'(dut.r_drop), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("redir_stale_hidden", 32'(out_valid), 32'd0);
    end
    tick();
    check_out("redir_target", 16'h40, 32'h140, 1'b1);
    tick();
    check_out("redir_next", 16'h41, 32'h141, 1'b1);

    // Redirect together with stall and an arriving response.
    stall = 1'b1;
    tick();
    check_out("rs_hold0", 16'h41, 32'h141, 1'b1);
    tick();
    check_out("rs_hold1", 16'h41, 32'h141, 1'b1);
    check_val("rs_rvalid", 32'(imem_rvalid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check_out("rs_bubble", 16'h0, 32'h0, 1'b0);
    check_val("rs_drop", 32'(dut.r_drop), 32'd1);
    tick();
    check_val("rs_stale_hidden", 32'(out_valid), 32'd0);
    check_val("rs_drop_done", 32'(dut.r_drop), 32'd0);
    expect_next("rs_target", 16'h0080);

    // Address wrap at the top of the 16-bit space.
    lat         = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    expect_next("wrap0", 16'hFFFE);
    expect_next("wrap1", 16'hFFFF);
    expect_next("wrap2", 16'h0000);
    check_val("wrap_addr0", 32'(seen_addr0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
